// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry path:
// debounce states, per-scan results, column drive patterns and operand sizing.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } scan_result_t;

    localparam int DIGITS    = 4;
    localparam int OPERAND_W = 16;
    localparam int CODE_W    = 4;

    // Active-low column drive, column 0 in the low nibble.
    localparam logic [15:0] COL_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return COL_PATTERNS[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner: synchronises rows, steps the column drive and
// reduces each full scan of 16 key samples to NONE / ONE(code) / MULTI.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    output logic              scan_done,
    output logic [1:0]        result,
    output logic [CODE_W-1:0] code
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]        row_meta_reg;
    logic [3:0]        row_sync_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [1:0]        col_idx_reg;
    logic [3:0]        col_reg;
    logic              win_last;
    logic              last_d1_reg;
    logic              last_d2_reg;
    logic [1:0]        idx_d1_reg;
    logic [1:0]        idx_d2_reg;
    logic [1:0]        acc_hits_reg;
    logic [CODE_W-1:0] acc_code_reg;
    logic              done_reg;
    scan_result_t      result_reg;
    logic [CODE_W-1:0] code_reg;

    logic [3:0]        row_low;
    logic [2:0]        low_count;
    logic [1:0]        col_hits;
    logic [1:0]        col_row;
    logic [2:0]        hit_sum;
    logic [1:0]        hits_next;
    logic [CODE_W-1:0] code_next;

    assign win_last = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row;
            row_sync_reg <= row_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            col_idx_reg <= 2'd0;
            col_reg     <= col_pattern(2'd0);
        end else if (win_last) begin
            div_cnt_reg <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_reg     <= col_pattern(col_idx_reg + 2'd1);
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // The synchroniser delays row by two cycles, so the "last cycle of the
    // window" marker and its column index are delayed to match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d1_reg <= 1'b0;
            last_d2_reg <= 1'b0;
            idx_d1_reg  <= 2'd0;
            idx_d2_reg  <= 2'd0;
        end else begin
            last_d1_reg <= win_last;
            last_d2_reg <= last_d1_reg;
            idx_d1_reg  <= col_idx_reg;
            idx_d2_reg  <= idx_d1_reg;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_row_low
        assign row_low[gi] = ~row_sync_reg[gi];
    end

    always_comb begin
        low_count = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                  + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        col_hits  = (low_count >= 3'd2) ? 2'd2 : low_count[1:0];
        col_row   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) begin
                col_row = 2'(r);
            end
        end
        hit_sum   = {1'b0, acc_hits_reg} + {1'b0, col_hits};
        hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_next = (col_hits == 2'd1) ? {col_row, idx_d2_reg} : acc_code_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hits_reg <= 2'd0;
            acc_code_reg <= '0;
            done_reg     <= 1'b0;
            result_reg   <= NONE;
            code_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            if (last_d2_reg) begin
                if (idx_d2_reg == 2'd3) begin
                    done_reg     <= 1'b1;
                    code_reg     <= code_next;
                    acc_hits_reg <= 2'd0;
                    acc_code_reg <= '0;
                    case (hits_next)
                        2'd0:    result_reg <= NONE;
                        2'd1:    result_reg <= ONE;
                        default: result_reg <= MULTI;
                    endcase
                end else begin
                    acc_hits_reg <= hits_next;
                    acc_code_reg <= code_next;
                end
            end
        end
    end

    assign col       = col_reg;
    assign scan_done = done_reg;
    assign result    = result_reg;
    assign code      = code_reg;

endmodule

// File: rtl/keypad_entry.sv
// Keypad operand entry: debounces scanned keys, shifts accepted hex digits into
// a 16-bit operand and hands it to the calculator on enter.
module keypad_entry
    import calc_pkg::*;
#(
    parameter int SCAN_DIV  = 2048,
    parameter int DEB_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        enter,
    input  logic        clear,
    input  logic        busy,
    output logic [15:0] data,
    output logic        data_valid,
    output logic [2:0]  digit_count,
    output logic        key_strobe,
    output logic [3:0]  key_code
);

    localparam int CNT_W = (DEB_SCANS > 1) ? $clog2(DEB_SCANS + 1) : 1;
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEB_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic              scan_done;
    logic [1:0]        scan_result;
    logic [CODE_W-1:0] scan_code;
    logic              is_one;

    deb_state_t        state_reg, state_next;
    logic [CODE_W-1:0] cand_reg, cand_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              accept;

    logic [OPERAND_W-1:0] data_reg;
    logic [2:0]           count_reg;
    logic                 data_valid_reg;
    logic                 pend_reg;
    logic                 key_strobe_reg;
    logic [CODE_W-1:0]    key_code_reg;
    logic [OPERAND_W-1:0] base_data;
    logic [2:0]           base_count;

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .scan_done (scan_done),
        .result    (scan_result),
        .code      (scan_code)
    );

    assign is_one = (scan_result == ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
        end
    end

    // MULTI is treated like NONE everywhere: it never builds a press count.
    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        if (scan_done) begin
            case (state_reg)
                IDLE: begin
                    if (is_one) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                        if (cnt_next >= DEB_TARGET) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (is_one) begin
                        cnt_next  = (scan_code == cand_reg) ? cnt_reg + CNT_ONE : CNT_ONE;
                        cand_next = scan_code;
                        if (cnt_next >= DEB_TARGET) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (!is_one) begin
                        cnt_next   = CNT_ONE;
                        state_next = (cnt_next >= DEB_TARGET) ? IDLE : RELEASE_DEB;
                    end
                end
                RELEASE_DEB: begin
                    if (is_one) begin
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                        if (cnt_next >= DEB_TARGET) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // After a hand-off the operand stays visible for the data_valid cycle and
    // is zeroed one cycle later; a digit arriving then lands on the fresh operand.
    always_comb begin
        base_data  = pend_reg ? '0 : data_reg;
        base_count = pend_reg ? 3'd0 : count_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg       <= '0;
            count_reg      <= 3'd0;
            data_valid_reg <= 1'b0;
            pend_reg       <= 1'b0;
            key_strobe_reg <= 1'b0;
            key_code_reg   <= '0;
        end else begin
            key_strobe_reg <= accept;
            if (accept) begin
                key_code_reg <= cand_next;
            end
            data_valid_reg <= 1'b0;
            pend_reg       <= 1'b0;
            if (clear) begin
                data_reg  <= '0;
                count_reg <= 3'd0;
            end else if (enter && !busy) begin
                data_valid_reg <= 1'b1;
                pend_reg       <= 1'b1;
                data_reg       <= base_data;
                count_reg      <= base_count;
            end else begin
                data_reg  <= base_data;
                count_reg <= base_count;
                if (accept && (base_count < 3'(DIGITS))) begin
                    data_reg  <= {base_data[OPERAND_W-CODE_W-1:0], cand_next};
                    count_reg <= base_count + 3'd1;
                end
            end
        end
    end

    assign data        = data_reg;
    assign data_valid  = data_valid_reg;
    assign digit_count = count_reg;
    assign key_strobe  = key_strobe_reg;
    assign key_code    = key_code_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad matrix model drives row from col,
// expected key codes and hand-off operands are queued and checked on strobes.
module tb_keypad_entry;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;
    localparam int SCAN_CYC  = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        enter;
    logic        clear;
    logic        busy;
    logic [15:0] data;
    logic        data_valid;
    logic [2:0]  digit_count;
    logic        key_strobe;
    logic [3:0]  key_code;

    logic [15:0] keys = '0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_codes[$];
    logic [15:0] exp_data[$];
    logic [3:0]  exp_code_v;
    logic [15:0] exp_data_v;

    keypad_entry #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .enter       (enter),
        .clear       (clear),
        .busy        (busy),
        .data        (data),
        .data_valid  (data_valid),
        .digit_count (digit_count),
        .key_strobe  (key_strobe),
        .key_code    (key_code)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && key_strobe) begin
            checks++;
            if (exp_codes.size() == 0) begin
                failures++;
                $display("FAIL key_strobe_unexpected: key_code=%h, no strobe expected", key_code);
            end else begin
                exp_code_v = exp_codes.pop_front();
                if (key_code !== exp_code_v) begin
                    failures++;
                    $display("FAIL key_code: got %h, expected %h", key_code, exp_code_v);
                end
            end
        end
        if (!reset && data_valid) begin
            checks++;
            if (exp_data.size() == 0) begin
                failures++;
                $display("FAIL data_valid_unexpected: data=%h, no hand-off expected", data);
            end else begin
                exp_data_v = exp_data.pop_front();
                if (data !== exp_data_v) begin
                    failures++;
                    $display("FAIL handoff_data: got %h, expected %h", data, exp_data_v);
                end
            end
        end
    end

    task automatic press_key(input logic [3:0] code, input int hold, input int rel, input bit want);
        if (want) exp_codes.push_back(code);
        keys = 16'(1) << code;
        repeat (hold * SCAN_CYC) @(posedge clk);
        #1 keys = '0;
        repeat (rel * SCAN_CYC) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ctrl(input logic e, input logic c, input logic b);
        @(posedge clk);
        #1 enter = e; clear = c; busy = b;
        @(posedge clk);
        #1 enter = 1'b0; clear = 1'b0; busy = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; enter = 1'b0; clear = 1'b0; busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (col !== 4'b1110) begin failures++; $display("FAIL reset_col: got %b, expected 1110", col); end
        checks++;
        if (data !== 16'h0 || digit_count !== 3'd0) begin
            failures++; $display("FAIL reset_operand: data=%h count=%0d, expected 0/0", data, digit_count);
        end
        checks++;
        if (data_valid !== 1'b0 || key_strobe !== 1'b0 || key_code !== 4'h0) begin
            failures++; $display("FAIL reset_strobes: dv=%b ks=%b kc=%h, expected 0/0/0", data_valid, key_strobe, key_code);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_basic;
        press_key(4'h6, 3, 3, 1'b1);
        @(negedge clk);
        checks++;
        if (data !== 16'h0006 || digit_count !== 3'd1 || key_code !== 4'h6) begin
            failures++; $display("FAIL basic_entry: data=%h count=%0d kc=%h, expected 0006/1/6", data, digit_count, key_code);
        end
        checks++;
        if (exp_codes.size() != 0) begin failures++; $display("FAIL basic_strobe_count: %0d strobes missing, expected 0", exp_codes.size()); end
        $display("basic entry: data=%h count=%0d", data, digit_count);
    endtask

    task automatic test_clear;
        pulse_ctrl(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (data !== 16'h0 || digit_count !== 3'd0 || key_code !== 4'h6) begin
            failures++; $display("FAIL clear: data=%h count=%0d kc=%h, expected 0000/0/6", data, digit_count, key_code);
        end
        $display("clear: data=%h count=%0d", data, digit_count);
    endtask

    task automatic test_fill_overflow;
        logic [3:0] seq [5];
        seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
        for (int i = 0; i < 5; i++) begin
            press_key(seq[i], 3, 3, 1'b1);
            $display("fill key %h: data=%h count=%0d", seq[i], data, digit_count);
        end
        @(negedge clk);
        checks++;
        if (data !== 16'h1234 || digit_count !== 3'd4) begin
            failures++; $display("FAIL fill_overflow: data=%h count=%0d, expected 1234/4", data, digit_count);
        end
        checks++;
        if (exp_codes.size() != 0) begin failures++; $display("FAIL fill_strobe_count: %0d strobes missing, expected 0", exp_codes.size()); end
        exp_data.push_back(16'h1234);
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data !== 16'h0 || digit_count !== 3'd0) begin
            failures++; $display("FAIL post_handoff: data=%h count=%0d, expected 0000/0", data, digit_count);
        end
        checks++;
        if (exp_data.size() != 0) begin failures++; $display("FAIL handoff_missing: %0d hand-offs missing, expected 0", exp_data.size()); end
        $display("hand-off done: data=%h count=%0d", data, digit_count);
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 3; i++) begin
            keys = 16'(1) << 5;
            repeat (SCAN_CYC) @(posedge clk);
            #1 keys = '0;
            repeat (SCAN_CYC) @(posedge clk);
            #1;
        end
        press_key(4'h5, 3, 3, 1'b1);
        @(negedge clk);
        checks++;
        if (data !== 16'h0005 || digit_count !== 3'd1) begin
            failures++; $display("FAIL bounce: data=%h count=%0d, expected 0005/1", data, digit_count);
        end
        $display("bounce: data=%h count=%0d", data, digit_count);
    endtask

    task automatic test_multi;
        keys = (16'(1) << 3) | (16'(1) << 9);
        repeat (4 * SCAN_CYC) @(posedge clk);
        #1;
        press_key(4'h3, 3, 3, 1'b1);
        @(negedge clk);
        checks++;
        if (data !== 16'h0053 || digit_count !== 3'd2 || key_code !== 4'h3) begin
            failures++; $display("FAIL multi_key: data=%h count=%0d kc=%h, expected 0053/2/3", data, digit_count, key_code);
        end
        checks++;
        if (exp_codes.size() != 0) begin failures++; $display("FAIL multi_strobe_count: %0d strobes missing, expected 0", exp_codes.size()); end
        $display("multi key: data=%h kc=%h", data, key_code);
    endtask

    task automatic test_busy_priority;
        pulse_ctrl(1'b0, 1'b1, 1'b0);
        press_key(4'hA, 3, 3, 1'b1);
        press_key(4'hB, 3, 3, 1'b1);
        pulse_ctrl(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data !== 16'h00AB || digit_count !== 3'd2) begin
            failures++; $display("FAIL busy_enter: data=%h count=%0d, expected 00AB/2", data, digit_count);
        end
        $display("busy enter: data=%h count=%0d", data, digit_count);
        pulse_ctrl(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data !== 16'h0 || digit_count !== 3'd0 || key_code !== 4'hB) begin
            failures++; $display("FAIL enter_clear: data=%h count=%0d kc=%h, expected 0000/0/B", data, digit_count, key_code);
        end
        $display("enter+clear: data=%h count=%0d", data, digit_count);
    endtask

    task automatic test_enter_empty;
        exp_data.push_back(16'h0);
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_data.size() != 0) begin failures++; $display("FAIL empty_handoff: %0d hand-offs missing, expected 0", exp_data.size()); end
        $display("empty enter: data=%h", data);
    endtask

    task automatic test_reset_mid;
        int n;
        press_key(4'h1, 3, 3, 1'b1);
        press_key(4'h2, 3, 3, 1'b1);
        @(negedge clk);
        checks++;
        if (data !== 16'h0012 || digit_count !== 3'd2) begin
            failures++; $display("FAIL pre_reset: data=%h count=%0d, expected 0012/2", data, digit_count);
        end
        n = 0;
        while (col != 4'b0111 && n < 40) begin @(posedge clk); n++; end
        while (col != 4'b1110 && n < 80) begin @(posedge clk); n++; end
        checks++;
        if (n >= 80) begin failures++; $display("FAIL col_sequence: no 0111->1110 step within %0d cycles, expected one", n); end
        #1 keys = 16'(1) << 7;
        repeat (24) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (col !== 4'b1110 || data !== 16'h0 || digit_count !== 3'd0 || data_valid !== 1'b0
            || key_strobe !== 1'b0 || key_code !== 4'h0) begin
            failures++;
            $display("FAIL mid_reset: col=%b data=%h count=%0d dv=%b ks=%b kc=%h, expected 1110/0000/0/0/0/0",
                     col, data, digit_count, data_valid, key_strobe, key_code);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        exp_codes.push_back(4'h7);
        repeat (3 * SCAN_CYC) @(posedge clk);
        #1 keys = '0;
        repeat (3 * SCAN_CYC) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data !== 16'h0007 || digit_count !== 3'd1 || key_code !== 4'h7) begin
            failures++; $display("FAIL post_reset_entry: data=%h count=%0d kc=%h, expected 0007/1/7", data, digit_count, key_code);
        end
        checks++;
        if (exp_codes.size() != 0) begin failures++; $display("FAIL post_reset_strobe: %0d strobes missing, expected 0", exp_codes.size()); end
        $display("reset mid-op: data=%h count=%0d", data, digit_count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_fill_overflow();
        test_bounce();
        test_multi();
        test_busy_priority();
        test_enter_empty();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 60000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Operand entry front end for the calculator. Scans a 4x4 hex keypad, debounces key presses, and assembles up to four hex digits into a 16-bit operand. On an enter strobe, it hands the operand to the calculator FSM's data/input-enable side. It is the producer counterpart to the result/display path: it drives `data` and `input_enable` into `fsm` in place of the raw switch bus.

## Interface
Parameters:
- SCAN_DIV, 2048: clk cycles each column is driven; minimum 2.
- DEB_SCANS, 4: consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- row  in  4  keypad rows, active-low (pulled up); synchronised internally with 2 flops.
- col  out  4  keypad column drive, active-low, one-hot-zero.
- enter  in  1  single-cycle pulse (already debounced upstream); requests operand hand-off.
- clear  in  1  single-cycle pulse; discards the digits entered so far.
- busy  in  1  high while the calculator is showing a result (`output_enable`); blocks hand-off.
- data  out  16  current operand, right-aligned hex digits.
- data_valid  out  1  one-cycle strobe; `data` is the handed-off operand in that cycle.
- digit_count  out  3  number of digits held, 0..4.
- key_strobe  out  1  one-cycle strobe on each accepted key press.
- key_code  out  4  hex value of the last accepted key.

## Operation
- **Column scan:** `col` steps through 1110, 1101, 1011, 0111, then repeats. Each pattern is held for SCAN_DIV cycles. The synchronised `row` is sampled on the last cycle of each column window. A full scan is four columns.
- **Key code:** key code = row_idx*4 + col_idx, where index 0 is the LSB.
- **Per-scan result** (from the 16 samples of one full scan):
  - NONE: no key low.
  - ONE(code): exactly one key low.
  - MULTI: two or more keys low. MULTI counts as NONE for release purposes and is never accepted.
- **Debounce FSM**, evaluated once per full scan:
  - IDLE
    - ONE(k) -> PRESS_DEB with cand=k and cnt=1.
  - PRESS_DEB
    - ONE(cand) -> cnt+1.
    - ONE(other) -> restart the count with the new candidate.
    - NONE/MULTI -> IDLE.
    - When cnt reaches DEB_SCANS: accept cand and go to HELD.
  - HELD
    - NONE/MULTI -> RELEASE_DEB with cnt=1.
    - ONE(any) -> stay in HELD.
  - RELEASE_DEB
    - NONE/MULTI -> cnt+1; at DEB_SCANS go to IDLE.
    - ONE(any) -> HELD.
  - If DEB_SCANS=1, acceptance and release happen on the first qualifying scan.
- **Accept:** pulse `key_strobe` and set `key_code` to cand. A held key produces exactly one accept.
- **Digit entry on accept:**
  - If digit_count < 4: data <= {data[11:0], code}, digit_count+1.
  - If digit_count = 4: `data` is unchanged; `key_strobe` still pulses.
- **Hand-off:** `enter` with busy=0 pulses `data_valid` with `data` equal to the held operand. In the next cycle, `data` and `digit_count` are cleared.
  - `enter` with busy=1 is ignored.
  - `enter` with digit_count=0 still hands off 0.
- **Clear:** zeroes `data` and `digit_count`. It does not change `key_code` or the debounce state.
- **Same-cycle priority:** clear > enter > accept.
  - An accepted digit that coincides with `enter` or `clear` is dropped; `key_strobe` still pulses.
  - `clear` coinciding with `enter` suppresses `data_valid`.
- **Reset (also mid-scan or mid-debounce):** FSM returns to IDLE, counters go to 0, and the scan restarts at column 0.

## Timing
- **Reset values:** col=4'b1110, data=0, data_valid=0, digit_count=0, key_strobe=0, key_code=0.
- **Outputs:** all outputs are registered.
- **`row` sampling:** delayed 2 cycles by the synchroniser. Sampling on the last window cycle with SCAN_DIV>=2 guarantees the column has settled (note the 2-cycle synchroniser delay).
- **`key_strobe`:** asserted 1 cycle after the sample that completes the accepting scan.
- **`digit_count`/`data`:** update in the same cycle as `key_strobe`.
- **Press-to-strobe latency:** between (DEB_SCANS-1)*4*SCAN_DIV and (DEB_SCANS+1)*4*SCAN_DIV + 3 cycles.
- **`data_valid`:** asserted in the cycle after `enter`. `data` holds the operand during that cycle and is 0 in the following cycle.
- **`busy`:** sampled in the same cycle as `enter`.

## Structure
- **Shared package** (`calc_pkg`):
  - debounce state enum (IDLE, PRESS_DEB, HELD, RELEASE_DEB)
  - scan result enum (NONE, ONE, MULTI)
  - column pattern constants
  - DIGITS=4 and operand width 16
- **Sub-module** `keypad_scan`, which contains:
  - the row synchroniser
  - the SCAN_DIV divider
  - the column counter and `col` drive
  - per-scan accumulation

  It outputs a one-cycle `scan_done` with `result`/`code`. `keypad_entry` holds the debounce FSM and the operand register.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_SCANS=2.
- **Basic entry:** press key row 1/col 2 (code 6) for 3 full scans, release for 3 scans -> exactly one key_strobe, key_code=6, data=16'h0006, digit_count=1.
- **Fill and overflow:** enter keys 1, 2, 3, 4, F -> data=16'h1234, digit_count=4, 5 key_strobes. Then enter -> data_valid pulse with data=16'h1234, then data=0 and digit_count=0.
- **Bounce:** toggle row low/high every scan for 6 scans, then hold low for 2 scans -> one key_strobe only after the stable hold.
- **Multi-key:** hold keys 3 and 9 together for 4 scans -> no key_strobe. Releasing 9 while 3 stays pressed for 2 scans -> key_strobe with key_code=3.
- **Busy gating and priority:**
  - With data=16'h00AB, enter while busy=1 -> no data_valid, data unchanged.
  - enter and clear in the same cycle -> no data_valid, data=0.
- **Reset mid-operation:** assert reset in PRESS_DEB with 2 digits held -> all outputs at reset values, col=1110. After release of reset the first accept needs a full DEB_SCANS again.
